// File: rtl/usb_cdc_pkg.sv
// Shared sizing for the USB CDC byte FIFOs, used by the endpoint side and the bus wrapper.
package usb_cdc_pkg;
    localparam int CDC_DW    = 8;
    localparam int CDC_AW    = 4;
    localparam int CDC_DEPTH = 2 ** CDC_AW;
endpackage

// File: rtl/usb_cdc_byte_fifo_if.sv
// Push/pop/status bundle between a CDC byte FIFO and whoever drives it.
interface usb_cdc_byte_fifo_if
    import usb_cdc_pkg::*;
#(
    parameter int DW = CDC_DW,
    parameter int AW = CDC_AW
);
    logic          flush;
    logic          push;
    logic [DW-1:0] wdata;
    logic          pop;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [AW-1:0] th;
    logic          level_above;
    logic          level_below;
    logic          overflow;
    logic          underflow;
    logic          clr_err;

    modport master (
        output flush, push, wdata, pop, th, clr_err,
        input  rdata, full, empty, level, level_above, level_below, overflow, underflow
    );

    modport slave (
        input  flush, push, wdata, pop, th, clr_err,
        output rdata, full, empty, level, level_above, level_below, overflow, underflow
    );
endinterface

// File: rtl/usb_cdc_fifo_mem.sv
// FIFO storage: one write port, one asynchronous read port; not reset so it can be swapped for a macro.
module usb_cdc_fifo_mem
    import usb_cdc_pkg::*;
#(
    parameter int DW = CDC_DW,
    parameter int AW = CDC_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/usb_cdc_byte_fifo.sv
// First-word-fall-through byte FIFO with occupancy level, threshold flags and sticky error flags.
module usb_cdc_byte_fifo
    import usb_cdc_pkg::*;
#(
    parameter int DW = CDC_DW,
    parameter int AW = CDC_AW
) (
    input  logic                clk,
    input  logic                rst,
    usb_cdc_byte_fifo_if.slave  fifo
);
    localparam int DEPTH = 2 ** AW;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full, empty;
    logic          push_ok, pop_ok;
    logic          mem_we;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign pop_ok  = fifo.pop & ~empty;
    assign push_ok = fifo.push & (~full | pop_ok);
    assign mem_we  = push_ok & ~fifo.flush & ~rst;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q & ~fifo.clr_err;
        underflow_d = underflow_q & ~fifo.clr_err;
        if (fifo.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            // A fresh error outranks clr_err in the same cycle.
            if (fifo.push & ~push_ok) overflow_d  = 1'b1;
            if (fifo.pop & ~pop_ok)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    usb_cdc_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (fifo.wdata),
        .raddr (rd_ptr_q),
        .rdata (fifo.rdata)
    );

    assign fifo.full        = full;
    assign fifo.empty       = empty;
    assign fifo.level       = level_q;
    assign fifo.level_above = (level_q > {1'b0, fifo.th});
    assign fifo.level_below = (level_q < {1'b0, fifo.th});
    assign fifo.overflow    = overflow_q;
    assign fifo.underflow   = underflow_q;
endmodule
